// File: rtl/neuro_pkg.sv
// Shared widths and state types for the neuron array and its downstream recorders.
package neuro_pkg;

  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned ISI_W_DEF = 16;
  localparam int unsigned DEPTH_DEF = 16;

  typedef enum logic {
    ISI_IDLE,
    ISI_ARMED
  } isi_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO with flush; a push while full is accepted only alongside a pop.
module sync_fifo_fwft #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int unsigned   DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (level == '0);
  assign full     = (level == DEPTH_LVL);
  assign do_pop   = pop & ~empty;
  // A pop frees the slot the full-cycle push lands in, so both proceed together.
  assign do_push  = push & (~full | do_pop);
  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/spike_event_recorder.sv
// Timestamps rising edges of a neuron spike into a FIFO and measures inter-spike intervals.
module spike_event_recorder
  import neuro_pkg::*;
#(
  parameter int unsigned TS_W   = TS_W_DEF,
  parameter int unsigned ISI_W  = ISI_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spike,
  input  logic              enable,
  input  logic              clear,
  output logic [TS_W-1:0]   ts_data,
  output logic              ts_valid,
  input  logic              ts_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [ISI_W-1:0]  last_isi,
  output logic              isi_valid
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic             spike_q;
  logic             spike_event;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TS_W-1:0]  ts_cnt;
  logic [ISI_W-1:0] isi_cnt;
  isi_state_t       state;

  assign spike_event = spike & ~spike_q & enable;
  assign ts_valid    = ~fifo_empty;

  sync_fifo_fwft #(
    .DATA_W (TS_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear),
    .push     (spike_event),
    .pop      (ts_ready),
    .data_in  (ts_cnt),
    .data_out (ts_data),
    .level    (level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spike_q  <= 1'b0;
      ts_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      spike_q <= spike;
      if (clear) begin
        ts_cnt   <= '0;
        overflow <= 1'b0;
      end else begin
        if (enable) ts_cnt <= ts_cnt + TS_W'(1);
        if (spike_event && fifo_full && !ts_ready) overflow <= 1'b1;
      end
    end
  end

  // isi_cnt restarts at 1 on each event so edges N enabled cycles apart report N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ISI_IDLE;
      isi_cnt   <= '0;
      last_isi  <= '0;
      isi_valid <= 1'b0;
    end else if (clear) begin
      state     <= ISI_IDLE;
      isi_cnt   <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      case (state)
        ISI_IDLE: begin
          if (spike_event) begin
            state   <= ISI_ARMED;
            isi_cnt <= ISI_W'(1);
          end
        end
        ISI_ARMED: begin
          if (spike_event) begin
            last_isi  <= isi_cnt;
            isi_valid <= 1'b1;
            isi_cnt   <= ISI_W'(1);
          end else if (enable && isi_cnt != ISI_MAX) begin
            isi_cnt <= isi_cnt + ISI_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_recorder.sv
// Bench for spike_event_recorder: a default build and a TS_W=4/ISI_W=4 build share stimulus.
module tb_spike_event_recorder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spike = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic ts_ready = 1'b0;

  logic [15:0] ts_data_a;
  logic        ts_valid_a;
  logic [4:0]  level_a;
  logic        overflow_a;
  logic [15:0] last_isi_a;
  logic        isi_valid_a;

  logic [3:0]  ts_data_b;
  logic        ts_valid_b;
  logic [4:0]  level_b;
  logic        overflow_b;
  logic [3:0]  last_isi_b;
  logic        isi_valid_b;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: timestamps kept as unbounded enabled-cycle counts.
  int mq[$];
  int m_en;
  int m_last_en;
  int m_isi_a;
  int m_isi_b;
  bit m_prev;
  bit m_ovf;
  bit m_armed;
  bit m_isi_valid;

  always #5 clk = ~clk;

  spike_event_recorder dut_a (
    .clk(clk), .reset(reset), .spike(spike), .enable(enable), .clear(clear),
    .ts_data(ts_data_a), .ts_valid(ts_valid_a), .ts_ready(ts_ready),
    .level(level_a), .overflow(overflow_a), .last_isi(last_isi_a), .isi_valid(isi_valid_a)
  );

  spike_event_recorder #(.TS_W(4), .ISI_W(4)) dut_b (
    .clk(clk), .reset(reset), .spike(spike), .enable(enable), .clear(clear),
    .ts_data(ts_data_b), .ts_valid(ts_valid_b), .ts_ready(ts_ready),
    .level(level_b), .overflow(overflow_b), .last_isi(last_isi_b), .isi_valid(isi_valid_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_last_en = 0; m_isi_a = 0; m_isi_b = 0;
    m_prev = 0; m_ovf = 0; m_armed = 0; m_isi_valid = 0;
  endtask

  task automatic model_step();
    bit evt;
    int n;
    evt = spike && !m_prev && enable;
    if (clear) begin
      mq.delete();
      m_en = 0; m_ovf = 0; m_armed = 0; m_isi_valid = 0;
    end else begin
      if (ts_ready && mq.size() > 0) void'(mq.pop_front());
      if (evt) begin
        if (mq.size() < 16) mq.push_back(m_en);
        else m_ovf = 1;
      end
      m_isi_valid = 0;
      if (evt) begin
        if (m_armed) begin
          n = m_en - m_last_en;
          m_isi_a = (n > 65535) ? 65535 : n;
          m_isi_b = (n > 15) ? 15 : n;
          m_isi_valid = 1;
        end
        m_armed = 1;
        m_last_en = m_en;
      end
      if (enable) m_en++;
    end
    m_prev = spike;
  endtask

  task automatic compare_outputs();
    check("level_a", level_a, mq.size());
    check("level_b", level_b, mq.size());
    check("ts_valid_a", ts_valid_a, mq.size() != 0);
    check("ts_valid_b", ts_valid_b, mq.size() != 0);
    check("overflow_a", overflow_a, m_ovf);
    check("overflow_b", overflow_b, m_ovf);
    check("isi_valid_a", isi_valid_a, m_isi_valid);
    check("isi_valid_b", isi_valid_b, m_isi_valid);
    check("last_isi_a", last_isi_a, m_isi_a);
    check("last_isi_b", last_isi_b, m_isi_b);
    if (mq.size() != 0) begin
      check("ts_data_a", ts_data_a, mq[0] & 32'hFFFF);
      check("ts_data_b", ts_data_b, mq[0] & 32'hF);
    end
  endtask

  task automatic step(input bit sp, input bit en, input bit rdy, input bit clr);
    @(negedge clk);
    spike = sp; enable = en; ts_ready = rdy; clear = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_outputs();
    check("rst_ts_data", ts_data_a, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single pulses at timestamps 10, 30, 35.
    for (int c = 0; c < 45; c++) begin
      step(c == 10 || c == 30 || c == 35, 1, 0, 0);
      if (c == 31) check("isi_sat_b", last_isi_b, 15);
    end
    check("p1_level", level_a, 3);
    check("p1_isi", last_isi_a, 5);

    // Long spike counts once.
    step(0, 1, 0, 1);
    for (int c = 0; c < 70; c++) step(c >= 12 && c < 62, 1, 0, 0);
    check("p2_level", level_a, 1);
    check("p2_ts", ts_data_a, 12);

    // 17 spikes into an undrained FIFO, then drain.
    step(0, 1, 0, 1);
    for (int c = 0; c < 72; c++) step(c % 4 == 0 && c < 68, 1, 0, 0);
    check("p3_level", level_a, 16);
    check("p3_ovf", overflow_a, 1);
    for (int c = 0; c < 20; c++) step(0, 1, 1, 0);
    check("p3_drained", ts_valid_a, 0);
    check("p3_ovf_sticky", overflow_a, 1);

    // Push and pop together while full.
    step(0, 1, 0, 1);
    for (int c = 0; c < 64; c++) step(c % 4 == 0, 1, 0, 0);
    step(1, 1, 1, 0);
    check("p4_level", level_a, 16);
    check("p4_ovf", overflow_a, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Clear with level 5 and a coincident spike edge.
    step(0, 1, 0, 1);
    for (int c = 0; c < 20; c++) step(c % 4 == 1, 1, 0, 0);
    check("p5_level", level_a, 5);
    step(1, 1, 1, 1);
    check("p5_clr_level", level_a, 0);
    check("p5_clr_isi_valid", isi_valid_a, 0);
    for (int c = 0; c < 8; c++) step(c == 3, 1, 0, 0);

    // Randomized traffic with gated timebase, backpressure and occasional clears.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);

    // Asynchronous reset in the middle of a cycle with data queued.
    step(0, 1, 0, 1);
    for (int c = 0; c < 10; c++) step(c % 3 == 0, 1, 0, 0);
    @(negedge clk);
    spike = 0; enable = 0; ts_ready = 0; clear = 0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) step(c == 4 || c == 11, 1, c > 20, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
